rib_arbiter: RTL

- Four-master, one-slave arbiter for the RIB memory/peripheral bus.
- Master 0 is the core data port (ex), master 1 the core fetch port (pc), master 2 the JTAG debug master, master 3 the UART download master.
- Round-robin arbitration with zero-latency grant for slaves that acknowledge in the same cycle. Supports multi-cycle slaves, locked bursts and a timeout watchdog.
- Generates the pipeline hold flag consumed by the core's ctrl block.

---
 rtl/rib_arbiter.sv | 84 ++++++++
 1 files changed

// File: rtl/rib_arbiter.sv
// rib_arbiter: four-master round-robin RIB bus arbiter with locked bursts and timeout watchdog
module rib_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      m_req_i,
    input  logic [3:0]      m_we_i,
    input  logic [3:0]      m_lock_i,
    input  logic [4*AW-1:0] m_addr_i,
    input  logic [4*DW-1:0] m_wdata_i,
    output logic [DW-1:0]   m_rdata_o,
    output logic [3:0]      m_ack_o,
    output logic [3:0]      m_err_o,
    output logic            s_req_o,
    output logic            s_we_o,
    output logic [AW-1:0]   s_addr_o,
    output logic [DW-1:0]   s_wdata_o,
    input  logic [DW-1:0]   s_rdata_i,
    input  logic            s_ack_i,
    output logic            hold_flag_o,
    output logic [1:0]      owner_o
);
    typedef enum logic [1:0] {IDLE, WAIT, LOCK} state_t;

    state_t      state, state_n;
    logic [1:0]  rr_ptr, owner, win, sel;
    logic [4:0]  burst_cnt, base, nb;
    logic [7:0]  to_cnt;
    logic        active, ack, tmo, go_lock;

    // round-robin winner: lowest offset from rr_ptr that is requesting
    always_comb begin
        win = rr_ptr;
        for (int i = 3; i >= 0; i--)
            if (m_req_i[rr_ptr + 2'(i)]) win = rr_ptr + 2'(i);
    end

    // grant, slave drive, completion and next-state decode (never depends on s_ack_i for s_*)
    always_comb begin
        sel     = (state == IDLE) ? win : owner;
        tmo     = !rst && state == WAIT && m_req_i[owner] && to_cnt == 8'(TIMEOUT);
        active  = !rst && m_req_i[sel] && !tmo;
        ack     = active && s_ack_i;
        base    = (state == IDLE) ? 5'd0 : burst_cnt;
        nb      = (int'(base) >= MAX_BURST) ? 5'(MAX_BURST) : base + 5'd1;
        go_lock = m_lock_i[sel] && int'(nb) < MAX_BURST;
        state_n = ack ? (go_lock ? LOCK : IDLE) : (tmo ? IDLE : (active ? WAIT : IDLE));
    end

    assign s_req_o     = active;
    assign s_we_o      = m_we_i[sel];
    assign s_addr_o    = m_addr_i[sel*AW +: AW];
    assign s_wdata_o   = m_wdata_i[sel*DW +: DW];
    assign m_rdata_o   = s_rdata_i;
    assign m_ack_o     = ack ? 4'b0001 << sel : 4'b0000;
    assign m_err_o     = tmo ? 4'b0001 << owner : 4'b0000;
    assign hold_flag_o = (m_req_i[0] & ~m_ack_o[0]) | (m_req_i[1] & ~m_ack_o[1]);
    assign owner_o     = owner;

    // state, pointer, owner and saturating burst/timeout counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= 2'd0;
            owner     <= 2'd0;
            burst_cnt <= 5'd0;
            to_cnt    <= 8'd0;
        end else begin
            state <= state_n;
            if (ack || tmo) rr_ptr <= sel + 2'd1;
            if (active) owner <= sel;
            if (ack) burst_cnt <= nb;
            else if (active && state == IDLE) burst_cnt <= 5'd0;
            if (active && !ack)
                to_cnt <= (state != WAIT) ? 8'd1 : (to_cnt < 8'(TIMEOUT) ? to_cnt + 8'd1 : to_cnt);
            else
                to_cnt <= 8'd0;
        end
    end
endmodule
